matmul_seq_unit: RTL and testbench
==================================

# matmul_seq_unit

Parametrised, handshaked N×N unsigned matrix multiplier for the TensorFlowE datapath. It is the successor to the fixed 4×4 free-running multiplier, adding configurable size and element width, and an explicit valid/ready job interface. It computes one output element per cycle. It also provides per-job accumulate and saturate modes and a sticky overflow flag. It sits between the operand staging registers and the result/readback logic.

## Interface
- N, default 4: matrix dimension (N ≥ 2)
- W, default 4: input element width, unsigned
- OW, default 8: output element width, unsigned (OW ≥ W)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  job request; accepted when start && in_ready at a rising edge
- in_ready  out  1  high exactly when FSM is IDLE
- matrixA  in  N*N*W  operand A, row-major; element (i,j) at bits [(i*N+j)*W +: W]
- matrixB  in  N*N*W  operand B, same packing
- acc_en  in  1  sampled at accept; 1 = add product to current result contents, 0 = overwrite
- sat_en  in  1  sampled at accept; 1 = clamp to 2^OW-1, 0 = wrap modulo 2^OW
- result  out  N*N*OW  result matrix, row-major; element (i,j) at [(i*N+j)*OW +: OW]
- out_valid  out  1  result complete and stable
- out_ready  in  1  consumer accepts result when out_valid && out_ready
- busy  out  1  high in COMPUTE
- ovf  out  1  at least one element of the current job exceeded 2^OW-1 before clamp/wrap

## Operation
- FSM states:
  - IDLE: in_ready=1. On accept, register A, B, acc_en and sat_en; clear ovf and the element index e; go to COMPUTE.
  - COMPUTE: each cycle, compute element e=(i,j), with i=e/N and j=e%N, in row-major order.
    - dot = Σk A[i][k]·B[k][j], at full width 2W+clog2(N).
    - sum = dot + (acc_en ? result[e] : 0), at full width.
    - If sum > 2^OW-1, set ovf. Write sat_en ? 2^OW-1 : sum[OW-1:0] into result[e].
    - Increment e. After writing e=N*N-1, go to DONE.
  - DONE: out_valid=1 and result is held. On out_valid && out_ready, go to IDLE.
- start is ignored outside IDLE; operand changes after accept have no effect.
- result keeps its contents across jobs, which is required for acc_en. In COMPUTE it is partially updated and is valid only while out_valid=1.
- ovf is valid while out_valid=1 and holds until the next accept.
- All arithmetic is unsigned; there is no truncation before the final clamp/wrap.

## Timing
- Reset values (asynchronous, while rst=0):
  - State IDLE, so in_ready=1.
  - busy=0, out_valid=0, ovf=0.
  - result=0, e=0.
  - Captured operands and modes cleared to 0.
- Let the accept edge be T.
  - Element e is written at edge T+1+e.
  - Transition to DONE is at edge T+N*N, so out_valid=1 from then on (16 cycles for N=4).
- The output handshake edge returns the FSM to IDLE. in_ready rises the cycle after the handshake, so the minimum job period is N*N+2 cycles.
- out_ready low holds DONE indefinitely, with result and ovf stable.
- rst asserted mid-COMPUTE or mid-DONE aborts the job immediately with no partial out_valid. Because result is cleared to 0, the next accumulate job starts from zero.
- One dot product (N multipliers plus an adder tree) is evaluated combinationally per cycle; there is no pipelining inside COMPUTE.

## Test plan
1. Identity, N=4, W=4, OW=8, acc_en=0, sat_en=0: A=I and B[i][j]=i*4+j -> out_valid exactly 16 cycles after accept, result==B, ovf=0.
2. Accumulate: A=B=all 1 with acc_en=0 -> every element is 4. Complete the handshake, then rerun with acc_en=1 -> every element is 8. Third run with acc_en=0 -> back to 4.
3. Overflow: A=B=all 15, dot=900.
   - sat_en=1 -> every element is 255, ovf=1.
   - sat_en=0, acc_en=0 -> every element is 132, ovf=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse start with new operands during DONE. Required: out_valid stays 1, result is unchanged, in_ready=0, the new start is not taken, and in_ready=1 the cycle after the out_ready handshake.
5. Reset mid-job: assert rst at cycle 7 of COMPUTE -> out_valid=0, busy=0, in_ready=1 and result=0 immediately. The next job (test 1 stimulus) completes correctly after 16 cycles.
6. Reparametrisation, N=2, W=8, OW=18: A=B=all 255, acc_en=0 -> every element is 130050, ovf=0, out_valid 4 cycles after accept.

Source files
------------

// File: rtl/matmul_seq_unit.sv
// matmul_seq_unit: handshaked N x N unsigned matrix multiplier.
// Produces one result element per cycle in row-major order.
// The result array persists across jobs so that accumulate mode can add onto it.
// Each element can either clamp or wrap, and a sticky flag records
// whether any element of the current job overflowed.
module matmul_seq_unit #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int OW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                in_ready,
    input  logic [N*N*W-1:0]    matrixA,
    input  logic [N*N*W-1:0]    matrixB,
    input  logic                acc_en,
    input  logic                sat_en,
    output logic [N*N*OW-1:0]   result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                ovf
);

    localparam int NN = N * N;
    localparam int EW = (NN > 1) ? $clog2(NN) : 1;
    // Full dot-product width: N products of two W-bit values.
    localparam int DW = 2 * W + $clog2(N);
    // One extra bit so that dot + previous result never loses a carry.
    localparam int SW = ((DW > OW) ? DW : OW) + 1;
    localparam logic [SW-1:0] MAXV = SW'({OW{1'b1}});

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state;
    logic [EW-1:0]        e;
    logic [NN*W-1:0]      a_q;
    logic [NN*W-1:0]      b_q;
    logic                 acc_q;
    logic                 sat_q;
    logic [NN*OW-1:0]     result_q;
    logic                 ovf_q;

    int                   row;
    int                   col;
    logic [W-1:0]         a_el;
    logic [W-1:0]         b_el;
    logic [2*W-1:0]       prod;
    logic [DW-1:0]        dot;
    logic [OW-1:0]        old;
    logic [SW-1:0]        sum;
    logic                 over;
    logic [OW-1:0]        wval;

    // Dot product of row i of A with column j of B for the current element.
    // The sum is then formed at full width, and the clamp or wrap value is chosen.
    always_comb begin
        row  = int'(e) / N;
        col  = int'(e) % N;
        a_el = '0;
        b_el = '0;
        prod = '0;
        dot  = '0;
        for (int k = 0; k < N; k++) begin
            a_el = a_q[(row * N + k) * W +: W];
            b_el = b_q[(k * N + col) * W +: W];
            prod = a_el * b_el;
            dot  = dot + DW'(prod);
        end
        old  = acc_q ? result_q[int'(e) * OW +: OW] : '0;
        sum  = SW'(dot) + SW'(old);
        over = (sum > MAXV);
        wval = (sat_q && over) ? {OW{1'b1}} : sum[OW-1:0];
    end

    // Job control: capture on accept, write one element per cycle, hold until drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            e        <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= 1'b0;
            sat_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= matrixA;
                        b_q   <= matrixB;
                        acc_q <= acc_en;
                        sat_q <= sat_en;
                        ovf_q <= 1'b0;
                        e     <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    result_q[int'(e) * OW +: OW] <= wval;
                    if (over) begin
                        ovf_q <= 1'b1;
                    end
                    if (e == EW'(NN - 1)) begin
                        state <= DONE;
                    end else begin
                        e <= e + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == COMPUTE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_matmul_seq_unit.sv
// Directed testbench for matmul_seq_unit. It uses a 4x4/4-bit/8-bit instance
// and a 2x2/8-bit/18-bit instance that share one clock and one reset.
module tb_matmul_seq_unit;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int OW = 8;

    logic                clk;
    logic                rst;
    logic                start;
    logic                in_ready;
    logic [N*N*W-1:0]    matrix_a;
    logic [N*N*W-1:0]    matrix_b;
    logic                acc_en;
    logic                sat_en;
    logic [N*N*OW-1:0]   result;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                ovf;

    logic                start2;
    logic                in_ready2;
    logic [31:0]         matrix_a2;
    logic [31:0]         matrix_b2;
    logic [71:0]         result2;
    logic                out_valid2;
    logic                out_ready2;
    logic                busy2;
    logic                ovf2;

    int total;
    int passed;
    int fails;

    logic [63:0]  a_id;
    logic [63:0]  b_seq;
    logic [127:0] r_seq;

    matmul_seq_unit #(.N(N), .W(W), .OW(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
        .matrixA(matrix_a), .matrixB(matrix_b), .acc_en(acc_en), .sat_en(sat_en),
        .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    matmul_seq_unit #(.N(2), .W(8), .OW(18)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_ready(in_ready2),
        .matrixA(matrix_a2), .matrixB(matrix_b2), .acc_en(1'b0), .sat_en(1'b0),
        .result(result2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a job, scramble the operand inputs, and verify the exact completion latency.
    task automatic run_job(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic acc, input logic sat);
        check({tag, " in_ready before"}, 128'(in_ready), 128'd1);
        matrix_a = a;
        matrix_b = b;
        acc_en   = acc;
        sat_en   = sat;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        matrix_a = ~a;
        matrix_b = ~b;
        acc_en   = ~acc;
        sat_en   = ~sat;
        check({tag, " busy after accept"}, 128'(busy), 128'd1);
        repeat (N * N - 1) tick();
        check({tag, " out_valid early"}, 128'(out_valid), 128'd0);
        tick();
        check({tag, " out_valid at 16"}, 128'(out_valid), 128'd1);
        check({tag, " busy in done"}, 128'(busy), 128'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after hs"}, 128'(in_ready), 128'd1);
        check({tag, " out_valid after hs"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        fails = 0;
        start = 1'b0;
        matrix_a = '0;
        matrix_b = '0;
        acc_en = 1'b0;
        sat_en = 1'b0;
        out_ready = 1'b0;
        start2 = 1'b0;
        matrix_a2 = '0;
        matrix_b2 = '0;
        out_ready2 = 1'b0;

        a_id  = '0;
        b_seq = '0;
        r_seq = '0;
        for (int i = 0; i < N; i++) a_id[(i * N + i) * W +: W] = 4'd1;
        for (int k = 0; k < N * N; k++) begin
            b_seq[k * W +: W]  = 4'(k);
            r_seq[k * OW +: OW] = 8'(k);
        end

        // Reset state
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset busy", 128'(busy), 128'd0);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset ovf", 128'(ovf), 128'd0);
        check("reset result", result, 128'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Test 1: identity times sequential matrix
        run_job("ident", a_id, b_seq, 1'b0, 1'b0);
        check("ident result", result, r_seq);
        check("ident ovf", 128'(ovf), 128'd0);
        handshake("ident");

        // Test 2: accumulate sequence 4 -> 8 -> 4
        run_job("ones", {16{4'h1}}, {16{4'h1}}, 1'b0, 1'b0);
        check("ones result", result, {16{8'd4}});
        handshake("ones");
        run_job("acc", {16{4'h1}}, {16{4'h1}}, 1'b1, 1'b0);
        check("acc result", result, {16{8'd8}});
        check("acc ovf", 128'(ovf), 128'd0);
        handshake("acc");
        run_job("noacc", {16{4'h1}}, {16{4'h1}}, 1'b0, 1'b0);
        check("noacc result", result, {16{8'd4}});
        handshake("noacc");

        // Test 3: overflow with clamp, then with wrap
        run_job("sat", {16{4'hF}}, {16{4'hF}}, 1'b0, 1'b1);
        check("sat result", result, {16{8'd255}});
        check("sat ovf", 128'(ovf), 128'd1);
        handshake("sat");
        run_job("wrap", {16{4'hF}}, {16{4'hF}}, 1'b0, 1'b0);
        check("wrap result", result, {16{8'd132}});
        check("wrap ovf", 128'(ovf), 128'd1);

        // Test 4: backpressure in DONE with a start pulse that must be ignored
        matrix_a = {16{4'h1}};
        matrix_b = {16{4'h1}};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("bp out_valid", 128'(out_valid), 128'd1);
        check("bp result", result, {16{8'd132}});
        check("bp ovf", 128'(ovf), 128'd1);
        check("bp in_ready", 128'(in_ready), 128'd0);
        check("bp busy", 128'(busy), 128'd0);
        handshake("bp");
        tick();
        check("bp start not taken", 128'(busy), 128'd0);
        check("bp still idle", 128'(in_ready), 128'd1);

        // Test 5: asynchronous reset during COMPUTE
        matrix_a = a_id;
        matrix_b = b_seq;
        acc_en = 1'b0;
        sat_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("rst busy before", 128'(busy), 128'd1);
        #2 rst = 1'b0;
        #1;
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        check("rst in_ready", 128'(in_ready), 128'd1);
        check("rst result", result, 128'd0);
        tick();
        rst = 1'b1;
        tick();
        run_job("post rst", a_id, b_seq, 1'b0, 1'b0);
        check("post rst result", result, r_seq);
        check("post rst ovf", 128'(ovf), 128'd0);
        handshake("post rst");

        // Test 6: 2x2, 8-bit operands, 18-bit results
        check("n2 in_ready", 128'(in_ready2), 128'd1);
        matrix_a2 = {4{8'hFF}};
        matrix_b2 = {4{8'hFF}};
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        matrix_a2 = '0;
        matrix_b2 = '0;
        repeat (3) tick();
        check("n2 out_valid early", 128'(out_valid2), 128'd0);
        tick();
        check("n2 out_valid at 4", 128'(out_valid2), 128'd1);
        check("n2 result", 128'(result2), 128'({4{18'd130050}}));
        check("n2 ovf", 128'(ovf2), 128'd0);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("n2 in_ready after hs", 128'(in_ready2), 128'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
